// File: rtl/uart_rcvr.sv
// ---------------------------------------------------------------------------
// uart_rcvr : UART receiver, 8N1 by default (8E1 when UART_RX_PARITY_EN)
//
// Turns the board RX pin into bytes for the host-command / image-load logic.
// It runs at the same bit period as the matching transmitter:
// BAUD_CNT_MAX+1 clocks per bit.
//
// Optional feature macro: UART_RX_PARITY_EN
//   When defined, one even-parity bit is expected between the data bits and
//   the stop bit. A mismatch pulses uart_parity_err together with
//   uart_data_valid, and the byte is still delivered.
//   When undefined, uart_parity_err is tied low.
//
// Ports
//   clock           in   system clock; every flop updates on its rising edge
//   reset           in   synchronous, active-high reset
//   uart_rx         in   asynchronous serial line, idles high
//   uart_data       out  [7:0] last correctly framed byte, LSB received first
//   uart_data_valid out  one-cycle pulse when uart_data updates
//   uart_frame_err  out  one-cycle pulse when the stop bit is sampled low
//   uart_parity_err out  one-cycle pulse on parity mismatch
//   uart_busy       out  high whenever the receiver is not in IDLE
// ---------------------------------------------------------------------------
module uart_rcvr #(
  parameter int BAUD_CNT_MAX = 217,
  parameter int HALF_CNT     = 108
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       uart_rx,
  output logic [7:0] uart_data,
  output logic       uart_data_valid,
  output logic       uart_frame_err,
  output logic       uart_parity_err,
  output logic       uart_busy
);

  localparam int CNT_W = $clog2(BAUD_CNT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX_C  = BAUD_CNT_MAX[CNT_W-1:0];
  localparam logic [CNT_W-1:0] CNT_HALF_C = HALF_CNT[CNT_W-1:0];

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_DONE,
    S_BREAK
  } state_t;

  // Two-flop synchronizer. Both flops reset to the idle (high) level, so a
  // reset never looks like a start bit.
  logic r_rx_meta;
  logic r_rx_s;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= uart_rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  // Receiver state
  state_t           r_state;
  logic [CNT_W-1:0] r_clk_cnt;
  logic [2:0]       r_bit_cnt;
  logic [7:0]       r_data;
  logic             r_valid;
  logic             r_frame_err;
  logic             r_busy;

  // Data-bit centre: the bit addressed by r_bit_cnt is captured on this cycle.
  logic w_data_sample;
  assign w_data_sample = (r_state == S_DATA) && (r_clk_cnt == CNT_MAX_C);

  // Deserialising register. Each bit is its own flop and is loaded only when
  // its index is being sampled, so no shifting logic is needed.
  logic       r_shift [8];
  logic [7:0] w_shift;

  for (genvar gi = 0; gi < 8; gi++) begin : g_shift
    always_ff @(posedge clock) begin
      if (reset) begin
        r_shift[gi] <= 1'b0;
      end else if (w_data_sample && (r_bit_cnt == 3'(gi))) begin
        r_shift[gi] <= r_rx_s;
      end
    end
    assign w_shift[gi] = r_shift[gi];
  end

`ifdef UART_RX_PARITY_EN
  logic r_par_bit;
  logic r_parity_err;
`endif

  // Main FSM. The strobes default low every cycle, so each one is high for
  // exactly the cycle after the transition that sets it.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_clk_cnt   <= '0;
      r_bit_cnt   <= 3'd0;
      r_data      <= 8'h00;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_busy      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_bit    <= 1'b0;
      r_parity_err <= 1'b0;
`endif
    end else begin
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_parity_err <= 1'b0;
`endif

      case (r_state)
        S_IDLE: begin
          r_clk_cnt <= '0;
          if (!r_rx_s) begin
            r_state <= S_START;
            r_busy  <= 1'b1;
          end
        end

        // Re-check the start bit at its centre; a line that has already
        // returned high was a glitch and is dropped silently.
        S_START: begin
          if (r_clk_cnt == CNT_HALF_C) begin
            r_clk_cnt <= '0;
            if (!r_rx_s) begin
              r_state   <= S_DATA;
              r_bit_cnt <= 3'd0;
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end

        // The counter was cleared at the start-bit centre, so each terminal
        // count lands on the centre of the next bit.
        S_DATA: begin
          if (r_clk_cnt == CNT_MAX_C) begin
            r_clk_cnt <= '0;
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              r_state <= S_PARITY;
`else
              r_state <= S_STOP;
`endif
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end

`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (r_clk_cnt == CNT_MAX_C) begin
            r_clk_cnt <= '0;
            r_par_bit <= r_rx_s;
            r_state   <= S_STOP;
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
`endif

        // The stop bit is judged at its centre and IDLE is re-entered before
        // the bit ends, so a start bit that immediately follows is not missed.
        S_STOP: begin
          if (r_clk_cnt == CNT_MAX_C) begin
            r_clk_cnt <= '0;
            if (r_rx_s) begin
              r_state <= S_DONE;
            end else begin
              r_frame_err <= 1'b1;
              r_state     <= S_BREAK;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end

        S_DONE: begin
          r_data  <= w_shift;
          r_valid <= 1'b1;
`ifdef UART_RX_PARITY_EN
          // Even parity: the received bit must equal the XOR of the data.
          r_parity_err <= (r_par_bit != (^w_shift));
`endif
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end

        // A line held low (break or framing fault) must go high before
        // another start bit can be recognised.
        S_BREAK: begin
          r_clk_cnt <= '0;
          if (r_rx_s) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end

        default: begin
          r_state   <= S_IDLE;
          r_clk_cnt <= '0;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

  assign uart_data       = r_data;
  assign uart_data_valid = r_valid;
  assign uart_frame_err  = r_frame_err;
  assign uart_busy       = r_busy;
`ifdef UART_RX_PARITY_EN
  assign uart_parity_err = r_parity_err;
`else
  assign uart_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rcvr.sv
// ---------------------------------------------------------------------------
// tb_uart_rcvr : directed self-checking bench for uart_rcvr
//
// The serial line is driven one bit period at a time, shortly after a rising
// clock edge. A negative-edge monitor counts output strobes and records the
// captured bytes and their cycle numbers. Define UART_RX_PARITY_EN to exercise
// the 8E1 build.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_rcvr;

  localparam int BIT = 218;
`ifdef UART_RX_PARITY_EN
  localparam int NBITS = 11;
  localparam int LAT   = 2075 + 218;
`else
  localparam int NBITS = 10;
  localparam int LAT   = 2075;
`endif

  logic       clock = 1'b0;
  logic       reset;
  logic       uart_rx;
  logic [7:0] uart_data;
  logic       uart_data_valid;
  logic       uart_frame_err;
  logic       uart_parity_err;
  logic       uart_busy;

  uart_rcvr dut (
    .clock           (clock),
    .reset           (reset),
    .uart_rx         (uart_rx),
    .uart_data       (uart_data),
    .uart_data_valid (uart_data_valid),
    .uart_frame_err  (uart_frame_err),
    .uart_parity_err (uart_parity_err),
    .uart_busy       (uart_busy)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Output monitor
  int         n_valid = 0;
  int         n_frame = 0;
  int         n_par = 0;
  int         n_par_lone = 0;
  int         n_both = 0;
  int         last_valid_cyc = 0;
  int         prev_valid_cyc = 0;
  logic [7:0] last_data = 8'h00;
  logic [7:0] prev_data = 8'h00;

  always @(negedge clock) begin
    if (uart_data_valid) begin
      n_valid        <= n_valid + 1;
      prev_valid_cyc <= last_valid_cyc;
      last_valid_cyc <= cyc;
      prev_data      <= last_data;
      last_data      <= uart_data;
    end
    if (uart_frame_err) n_frame <= n_frame + 1;
    if (uart_parity_err) n_par <= n_par + 1;
    if (uart_parity_err && !uart_data_valid) n_par_lone <= n_par_lone + 1;
    if (uart_frame_err && uart_data_valid) n_both <= n_both + 1;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    uart_rx = b;
    wait_clk(BIT);
  endtask

  // Start, 8 data bits LSB first, correct even parity (8E1 build), stop.
  task automatic send_frame(input logic [7:0] d, input logic stop_b);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(^d);
`endif
    drive_bit(stop_b);
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic send_frame_badpar(input logic [7:0] d);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(~(^d));
    drive_bit(1'b1);
  endtask
`endif

  int         t0;
  int         v0;
  logic [7:0] d5a;

  initial begin
    reset   = 1'b1;
    uart_rx = 1'b1;
    wait_clk(5);
    reset = 1'b0;
    wait_clk(5);

    check_val("reset_data",   32'(uart_data), 32'h00);
    check_val("reset_valid",  32'(uart_data_valid), 0);
    check_val("reset_ferr",   32'(uart_frame_err), 0);
    check_val("reset_perr",   32'(uart_parity_err), 0);
    check_val("reset_busy",   32'(uart_busy), 0);

    // Single good frame
    t0 = cyc;
    send_frame(8'hA5, 1'b1);
    uart_rx = 1'b1;
    wait_clk(300);
    check_val("a5_count",   32'(n_valid), 1);
    check_val("a5_data",    32'(uart_data), 32'hA5);
    check_val("a5_mon",     32'(last_data), 32'hA5);
    check_val("a5_latency", 32'(last_valid_cyc - t0), 32'(LAT));
    check_val("a5_ferr",    32'(n_frame), 0);
    check_val("a5_busy",    32'(uart_busy), 0);
    $display("txn a5: data=%02h valid_count=%0d latency=%0d", uart_data, n_valid, last_valid_cyc - t0);

    // Start-bit glitch
    uart_rx = 1'b0;
    wait_clk(50);
    check_val("glitch_busy_mid", 32'(uart_busy), 1);
    uart_rx = 1'b1;
    wait_clk(70);
    check_val("glitch_busy_end", 32'(uart_busy), 0);
    check_val("glitch_valid",    32'(n_valid), 1);
    check_val("glitch_ferr",     32'(n_frame), 0);
    $display("txn glitch: busy=%0d valid_count=%0d", uart_busy, n_valid);

    // Framing error followed by a held-low line
    send_frame(8'h3C, 1'b0);
    uart_rx = 1'b0;
    wait_clk(1000);
    check_val("ferr_count",  32'(n_frame), 1);
    check_val("ferr_data",   32'(uart_data), 32'hA5);
    check_val("ferr_valid",  32'(n_valid), 1);
    check_val("ferr_busy",   32'(uart_busy), 1);
    uart_rx = 1'b1;
    wait_clk(10);
    check_val("ferr_release", 32'(uart_busy), 0);
    wait_clk(300);
    check_val("ferr_nostart", 32'(n_valid), 1);
    $display("txn 3c_ferr: frame_err_count=%0d data=%02h", n_frame, uart_data);

    // Zero-gap back-to-back frames
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    uart_rx = 1'b1;
    wait_clk(300);
    check_val("b2b_count",  32'(n_valid), 3);
    check_val("b2b_first",  32'(prev_data), 32'h00);
    check_val("b2b_second", 32'(last_data), 32'hFF);
    check_val("b2b_gap",    32'(last_valid_cyc - prev_valid_cyc), 32'(NBITS * BIT));
    $display("txn b2b: %02h then %02h gap=%0d", prev_data, last_data, last_valid_cyc - prev_valid_cyc);

    // Reset during bit 4 of 8'h5A
    v0  = n_valid;
    d5a = 8'h5A;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(d5a[i]);
    uart_rx = d5a[4];
    wait_clk(100);
    reset = 1'b1;
    wait_clk(1);
    reset = 1'b0;
    uart_rx = 1'b1;
    wait_clk(2500);
    check_val("rst_data",  32'(uart_data), 32'h00);
    check_val("rst_valid", 32'(n_valid), 32'(v0));
    check_val("rst_busy",  32'(uart_busy), 0);
    send_frame(8'hC3, 1'b1);
    uart_rx = 1'b1;
    wait_clk(300);
    check_val("c3_count", 32'(n_valid), 32'(v0 + 1));
    check_val("c3_data",  32'(uart_data), 32'hC3);
    $display("txn reset_abort: data=%02h valid_count=%0d", uart_data, n_valid);

`ifdef UART_RX_PARITY_EN
    // Wrong parity bit: byte still delivered, parity error beside valid
    send_frame_badpar(8'h07);
    uart_rx = 1'b1;
    wait_clk(300);
    check_val("par_data",  32'(uart_data), 32'h07);
    check_val("par_count", 32'(n_par), 1);
    check_val("par_lone",  32'(n_par_lone), 0);
    $display("txn 07_badpar: data=%02h parity_err_count=%0d", uart_data, n_par);
`else
    check_val("par_never", 32'(n_par), 0);
`endif

    check_val("ferr_valid_overlap", 32'(n_both), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
